// File: rtl/bcd_xs3_seq.sv
// Sequential BCD-to-Excess-3 converter. It uses one shared digit converter and processes one digit per clock.
// Define BCD_XS3_SEQ_ERR_ABORT_EN to finish the word at the first digit greater than 9.
module bcd_xs3_seq #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_bcd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_xs3,
    output logic              out_err,
    output logic              busy
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_r;
    logic [IW-1:0]     idx_r;
    logic [4*NDIG-1:0] data_r;
    logic [4*NDIG-1:0] result_r;
    logic              err_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    logic [IW+1:0]     base_s;
    logic [3:0]        digit_s;
    logic [3:0]        conv_s;
    logic              bad_s;
    logic              last_s;

    // Excess-3 wraps modulo 16, so non-BCD codes still produce a defined value.
    function automatic logic [3:0] xs3_conv(input logic [3:0] d);
        return d + 4'd3;
    endfunction

    function automatic logic bcd_bad(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Select the current digit and run it through the shared converter.
    always_comb begin
        base_s  = {idx_r, 2'b00};
        digit_s = data_r[base_s +: 4];
        conv_s  = xs3_conv(digit_s);
        bad_s   = bcd_bad(digit_s);
`ifdef BCD_XS3_SEQ_ERR_ABORT_EN
        last_s  = (idx_r == LAST_IDX) || bad_s;
`else
        last_s  = (idx_r == LAST_IDX);
`endif
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= {IW{1'b0}};
            data_r      <= {(4*NDIG){1'b0}};
            result_r    <= {(4*NDIG){1'b0}};
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        data_r     <= in_bcd;
                        result_r   <= {(4*NDIG){1'b0}};
                        err_r      <= 1'b0;
                        idx_r      <= {IW{1'b0}};
                        state_r    <= CONV;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONV: begin
                    result_r[base_s +: 4] <= conv_s;
                    err_r                 <= err_r | bad_s;
                    if (last_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                DONE: begin
                    // The release edge never captures, even when in_valid is high.
                    if (out_ready) begin
                        state_r     <= IDLE;
                        idx_r       <= {IW{1'b0}};
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    idx_r       <= {IW{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_xs3   = result_r;
    assign out_err   = err_r;

endmodule

// File: doc/bcd_xs3_seq.md
BCD_XS3_SEQ -- requirements
Module: bcd_xs3_seq

Interface
REQ-001 Parameter: NDIG, default 4, number of BCD digits per word; legal range 1..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous reset, active-low.
REQ-004 Port: in_valid  input  1  source offers in_bcd.
REQ-005 Port: in_ready  output  1  block can accept a word.
REQ-006 Port: in_bcd  input  4*NDIG  packed BCD word; digit 0 = bits [3:0].
REQ-007 Port: out_valid  output  1  converted word available.
REQ-008 Port: out_ready  input  1  sink accepts out_xs3.
REQ-009 Port: out_xs3  output  4*NDIG  packed Excess-3 result, same digit order as in_bcd.
REQ-010 Port: out_err  output  1  at least one input digit was greater than 9; qualified by out_valid.
REQ-011 Port: busy  output  1  high in CONV or DONE.

Function
REQ-012 Shall time-share one 4-bit BCD-to-Excess-3 converter across all digits, one digit per clock, starting at digit 0.
REQ-013 Converter arithmetic shall be digit + 3, truncated to 4 bits, for every input value 0..15; for example, A maps to D and F maps to 2.
REQ-014 FSM states shall be IDLE, CONV and DONE.
REQ-015 IDLE: in_ready=1. On in_valid=1 at a rising edge, the block shall capture in_bcd, clear the result register and error flag, set idx=0 and move to CONV.
REQ-016 CONV: in_ready=0. Each edge shall write conv(digit[idx]) into result digit idx and OR (digit[idx]>9) into the error flag.
REQ-017 CONV: when idx=NDIG-1, the next state shall be DONE; otherwise idx shall increment.
REQ-018 DONE: out_valid=1, and out_xs3 and out_err shall be stable. The block shall return to IDLE on the edge where out_ready=1.
REQ-019 Latency: capture at edge N; out_valid shall go high after edge N+NDIG. No early abort occurs when the macro is absent.
REQ-020 in_valid while CONV or DONE shall be ignored. No capture shall occur on the DONE-to-IDLE edge, so the minimum spacing between accepts is NDIG+2 cycles.
REQ-021 out_xs3 shall be driven from the result register at all times; it is only meaningful when out_valid=1.
REQ-022 idx shall be ceil(log2(NDIG)) bits wide, minimum 1, and shall never exceed NDIG-1.
REQ-023 Changes on in_bcd after capture shall not affect the result.

Reset
REQ-024 rst_n=0 shall immediately force state=IDLE, idx=0, the result register to 0 and the error flag to 0, regardless of the clock.
REQ-025 Output values during reset: in_ready=1, out_valid=0, out_xs3=0, out_err=0, busy=0.
REQ-026 Reset asserted during CONV or DONE shall discard the word in progress; no out_valid shall follow for that word.
REQ-027 Reset deassertion is synchronised externally to clk; the block adds no reset synchroniser.

Configuration
REQ-028 Macro: BCD_XS3_SEQ_ERR_ABORT_EN.
REQ-029 Macro defined: in CONV, the edge that converts a digit greater than 9 shall store conv(digit), set the error flag and go directly to DONE. Higher digits shall remain 0, and latency shall be idx_bad+1 cycles after capture.
REQ-030 Macro undefined: all NDIG digits shall always be converted, and the error flag shall be sticky for the word.

Verification (NDIG=4)
REQ-031 Accept 16'h1234 at edge N -> out_valid high after edge N+4, out_xs3=16'h4567, out_err=0.
REQ-032 Input 16'h9999, then 16'h0000 -> first result 16'hCCCC, second 16'h3333, out_err=0 for both; the second accept occurs no earlier than 6 cycles after the first.
REQ-033 Input 16'h12A4 -> macro undefined: out_xs3=16'h45D7, out_err=1, valid after 4 cycles. Macro defined: out_xs3=16'h00D7, out_err=1, valid after 2 cycles.
REQ-034 In DONE, hold out_ready=0 for 5 cycles while toggling in_valid and in_bcd -> out_valid, out_xs3 and out_err stay constant and in_ready stays 0; out_ready=1 returns the block to IDLE on the next edge.
REQ-035 Assert rst_n=0 mid-CONV after 2 digits of 16'h5678 -> outputs immediately take their reset values and no out_valid follows. After release, 16'h0421 converts to 16'h3754.
